// File: rtl/rng_arbiter.sv
// rng_arbiter
// Sequences the shared 4-lane 9-bit LFSR RNG and hands one 4-bit sample per
// cycle to one of NUM_REQ game requesters using round-robin arbitration.
// This block is the only driver of the RNG seed and init pins.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   reseed               single-cycle request to reseed the RNG
//   seed_mix[8:0]        external entropy, mixed into new seeds
//   rn_in[3:0]           RNG output bits
//   rng_init             RNG init pulse (high for the one SEED cycle)
//   rng_seed0..3[8:0]    RNG lane seeds
//   req[NUM_REQ-1:0]     level request per requester
//   grant[NUM_REQ-1:0]   one-hot grant pulse
//   rnd_out[3:0]         sample for the granted requester (holds otherwise)
//   rnd_valid            high with any grant bit
//   busy                 high whenever not serving
//
// state  | meaning
// SEED   | rng_init asserted for one cycle, seeds presented to RNG
// WARMUP | RNG free-running for WARMUP_CYCLES cycles, no grants
// SERVE  | one sample per cycle granted round-robin
module rng_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int WARMUP_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               reseed,
    input  logic [8:0]         seed_mix,
    input  logic [3:0]         rn_in,
    output logic               rng_init,
    output logic [8:0]         rng_seed0,
    output logic [8:0]         rng_seed1,
    output logic [8:0]         rng_seed2,
    output logic [8:0]         rng_seed3,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [3:0]         rnd_out,
    output logic               rnd_valid,
    output logic               busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [8:0] LANE0 = 9'h0A5;
    localparam logic [8:0] LANE1 = 9'h13C;
    localparam logic [8:0] LANE2 = 9'h1F0;
    localparam logic [8:0] LANE3 = 9'h067;

    localparam logic [7:0]       WARM_LAST = 8'(WARMUP_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W:0]   NREQ_W    = (PTR_W + 1)'(NUM_REQ);

    typedef enum logic [1:0] {
        ST_SEED,
        ST_WARMUP,
        ST_SERVE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             capture;
    logic [7:0]       warm_cnt;
    logic [8:0]       ent_cnt;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] sel_idx;
    logic             sel_found;
    logic [PTR_W:0]   cand_sum;
    logic [PTR_W-1:0] cand;

    // An all-zero LFSR state never leaves zero, so force such seeds to 1.
    function automatic logic [8:0] nonzero(input logic [8:0] v);
        return (v == 9'h000) ? 9'h001 : v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_SEED;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rng_init  = 1'b0;
        busy      = 1'b1;
        capture   = 1'b0;
        case (state)
            ST_SEED: begin
                rng_init  = 1'b1;
                state_nxt = ST_WARMUP;
            end
            ST_WARMUP: begin
                if (reseed) begin
                    capture   = 1'b1;
                    state_nxt = ST_SEED;
                end else if (warm_cnt == WARM_LAST) begin
                    state_nxt = ST_SERVE;
                end
            end
            ST_SERVE: begin
                busy = 1'b0;
                if (reseed) begin
                    capture   = 1'b1;
                    state_nxt = ST_SEED;
                end
            end
            default: state_nxt = ST_SEED;
        endcase
    end

    // Round-robin search starting at ptr; ptr + k stays below 2*NUM_REQ,
    // so a single conditional subtract implements the modulo.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, ptr} + (PTR_W + 1)'(k);
            if (cand_sum >= NREQ_W) begin
                cand_sum = cand_sum - NREQ_W;
            end
            cand = cand_sum[PTR_W-1:0];
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            warm_cnt  <= '0;
            ent_cnt   <= '0;
            ptr       <= '0;
            grant     <= '0;
            rnd_out   <= '0;
            rnd_valid <= 1'b0;
            rng_seed0 <= LANE0;
            rng_seed1 <= LANE1;
            rng_seed2 <= LANE2;
            rng_seed3 <= LANE3;
        end else begin
            ent_cnt   <= ent_cnt + 9'd1;
            warm_cnt  <= (state == ST_WARMUP) ? warm_cnt + 8'd1 : 8'd0;
            grant     <= '0;
            rnd_valid <= 1'b0;
            if (capture) begin
                rng_seed0 <= nonzero(ent_cnt ^ seed_mix ^ LANE0);
                rng_seed1 <= nonzero(ent_cnt ^ seed_mix ^ LANE1);
                rng_seed2 <= nonzero(ent_cnt ^ seed_mix ^ LANE2);
                rng_seed3 <= nonzero(ent_cnt ^ seed_mix ^ LANE3);
            end
            // Reseed outranks any pending request on the same edge.
            if (state == ST_SERVE && !reseed && sel_found) begin
                grant     <= NUM_REQ'(1) << sel_idx;
                rnd_valid <= 1'b1;
                rnd_out   <= rn_in;
                ptr       <= (sel_idx == PTR_LAST) ? '0 : sel_idx + 1'b1;
            end
        end
    end

endmodule
